// File: rtl/truth_table_sweeper_if.sv
// Bundle of signals between the truth-table sweep engine and the
// logic that commands it and observes its results.
// - The slave side is the sweeper itself.
// - The master side issues start and the expected table, provides the
//   function output, and reads back the sweep results.
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    localparam int TW = 2 ** N_IN;

    logic            start;
    logic [TW-1:0]   expected;
    logic            f_in;
    logic [N_IN-1:0] vec_out;
    logic            busy;
    logic            done;
    logic [TW-1:0]   table_out;
    logic [N_IN:0]   err_count;
    logic            pass;

    modport master (
        output start,
        output expected,
        output f_in,
        input  vec_out,
        input  busy,
        input  done,
        input  table_out,
        input  err_count,
        input  pass
    );

    modport slave (
        input  start,
        input  expected,
        input  f_in,
        output vec_out,
        output busy,
        output done,
        output table_out,
        output err_count,
        output pass
    );

endinterface

// File: rtl/truth_table_sweeper.sv
// Truth-table sweep engine.
// - Walks every input combination of an N_IN-input function.
// - Holds each vector for SETTLE_CYC cycles, then captures the function
//   output for one more cycle.
// - Builds the observed truth table and counts the positions that
//   differ from the expected table latched when the sweep started.
module truth_table_sweeper #(
    parameter int N_IN       = 3,
    parameter int SETTLE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    truth_table_sweeper_if.slave sweep_bus
);

    localparam int TW    = 2 ** N_IN;
    localparam int ERR_W = N_IN + 1;
    localparam int SW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    // Last settle count before moving on to capture, and last vector index
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] IDX_LAST    = '1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CAPTURE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [TW-1:0]    exp_q, exp_d;
    logic [TW-1:0]    table_q, table_d;
    logic [ERR_W-1:0] err_q, err_d;

    // State and datapath registers; reset clears everything at once, even mid-sweep
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            exp_q    <= '0;
            table_q  <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            exp_q    <= exp_d;
            table_q  <= table_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath updates; start is only honoured from IDLE or DONE
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        exp_d    = exp_q;
        table_d  = table_q;
        err_d    = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (sweep_bus.start) begin
                    exp_d    = sweep_bus.expected;
                    table_d  = '0;
                    err_d    = '0;
                    idx_d    = '0;
                    settle_d = '0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = CAPTURE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            CAPTURE: begin
                table_d[idx_q] = sweep_bus.f_in;
                if (sweep_bus.f_in != exp_q[idx_q]) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + N_IN'(1);
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The vector follows the index, which stays on the last vector once the sweep ends
    assign sweep_bus.vec_out   = idx_q;
    assign sweep_bus.busy      = (state_q == DRIVE) || (state_q == CAPTURE);
    assign sweep_bus.done      = (state_q == DONE);
    assign sweep_bus.table_out = table_q;
    assign sweep_bus.err_count = err_q;
    assign sweep_bus.pass      = (state_q == DONE) && (err_q == '0);

endmodule
